adc_frontend: RTL and testbench
===============================

# adc_frontend

Input conditioning stage between the 12-bit ADC pins and the demodulator input. Converts offset-binary ADC codes to 16-bit left-justified two's complement, removes DC with a leaky-integrator estimator, saturates the result and flags sustained ADC over-range. A settle state machine holds `data_valid` low until the DC estimate has absorbed a programmable number of samples. Output feeds the 16-bit demodulator data input, one sample per clock.

## Interface
- `DC_SHIFT`, 10: leaky-integrator time constant, 2^DC_SHIFT samples; legal 4..14.
- `OVR_LIMIT`, 16: consecutive over-range samples needed to set `ovr_flag`; legal 1..255.
- `SETTLE_CYC`, 1024: accepted samples absorbed before output is valid; legal 1..65535.
- `sys_clk`  in  1  sample clock, one ADC sample per rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `en`  in  1  pipeline advance; low = all state held.
- `adc_data_in`  in  12  raw ADC code, offset binary.
- `ovr_clr`  in  1  clears sticky `ovr_flag`.
- `data_out`  out  16  DC-removed, saturated signed sample.
- `data_valid`  out  1  `data_out` is a valid settled sample.
- `dc_est`  out  16  current signed DC estimate.
- `ovr_flag`  out  1  sticky over-range indicator.
- `settled`  out  1  state machine is in RUN.

## Operation
- Stage 1 (when `en`): `x = {~adc[11], adc[10:0], 4'b0}`, 16-bit signed. `ovr1 = (adc == 12'h000) || (adc == 12'hFFF)`.
- Stage 2 (when `en`):
  - Accumulator `acc` is signed, 16+DC_SHIFT bits. `dc = acc >>> DC_SHIFT`, truncated to 16 bits.
  - `y = x - dc`, computed at 17 bits.
  - `acc <= acc + sext(x) - sext(dc)` unless `ovr1`; over-range samples leave `acc` unchanged.
- Stage 3 (when `en`): `data_out <= sat16(y)`. Clamp to 0x7FFF / 0x8000.
- `dc_est` is the registered `dc` and changes only on stage-2 updates.
- Over-range counter is 8 bits, saturating, and advances at stage 2. It increments on `ovr1` and clears on a non-over-range sample. At the edge where it reaches OVR_LIMIT, `ovr_flag` is set.
- `ovr_flag` clears on `ovr_clr`. If set and clear happen in the same cycle, set wins.
- States:
  - SETTLE: entered on reset. A 16-bit counter increments on each stage-2 update. When the counter equals SETTLE_CYC-1 at an update, move to RUN.
  - RUN: held until reset.
- `settled` = (state == RUN).
- `data_valid` is the stage-3 valid bit. It goes high when the stage-2 update for that sample occurred in RUN and `en` was high, and drops low in any cycle with `en` low.
- `en` low:
  - No register changes, including counters, `acc`, `data_out` and `ovr_flag`; `ovr_clr` is still honoured.
  - `data_valid` = 0.
  - Samples presented while `en` is low are discarded.
- `sys_rst` high at any edge clears all registers, including `acc` and both counters, and returns state to SETTLE. This includes reset mid-run.

## Timing
- Reset values: `data_out` = 0, `data_valid` = 0, `dc_est` = 0, `ovr_flag` = 0, `settled` = 0.
- Latency from `adc_data_in` to `data_out` is 3 enabled edges. Sample i, with reset released before edge 1 and `en` continuously high:
  - captured at edge i+1;
  - stage-2 update at edge i+2;
  - on `data_out` after edge i+3.
- Samples 0..SETTLE_CYC-1 are settle samples. `settled` rises after edge SETTLE_CYC+1. The first valid sample is index SETTLE_CYC, and `data_valid` first rises after edge SETTLE_CYC+3.
- `ovr_flag` rises after the stage-2 edge (i+2) of the OVR_LIMIT-th consecutive over-range sample i.
- No backpressure: with `en` high, one output per clock.

## Test plan
- Reset then constant `adc_data_in` = 12'h800, `en` = 1 → all outputs 0 during reset; `settled` high after edge 1025; `data_valid` first high after edge 1027; `data_out` = 0 thereafter.
- Constant 12'hA00 (x = 0x2000) for 16384 samples → `dc_est` monotonically rises to within 0x0010 of 0x2000; final |`data_out`| ≤ 0x0010.
- Converge on 12'h100 (x = −0x7000), then step to 12'hFFE (x = 0x7FE0) → first post-step `data_out` = 0x7FFF (saturated); 12'h000 step from x = +0x7FE0 steady state → 0x8000.
- Over-range boundaries:
  - 15 × 12'hFFF then 12'h800 → `ovr_flag` stays 0 and `dc_est` is unchanged across the 15 samples.
  - 16 × 12'h000 → `ovr_flag` = 1 after edge i+2 of the 16th sample.
  - `ovr_clr` in the same cycle as the set → flag stays 1; `ovr_clr` later → 0.
- Mid-run `en` low for 100 cycles with a ramp input → `data_valid` = 0; `data_out`, `dc_est` and counters are frozen. After `en` returns, the output sequence resumes from the next sample presented, with no duplicates.
- One-cycle `sys_rst` pulse in RUN → all outputs 0 on the next edge; `data_valid` returns exactly SETTLE_CYC+3 enabled edges later.

Source files
------------

// File: rtl/adc_frontend.sv
// rtl/adc_frontend.sv - ADC offset-binary to signed conversion, DC removal, saturation, over-range and settle tracking
module adc_frontend #(
  parameter int DC_SHIFT   = 10,
  parameter int OVR_LIMIT  = 16,
  parameter int SETTLE_CYC = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        en,
  input  logic [11:0] adc_data_in,
  input  logic        ovr_clr,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic [15:0] dc_est,
  output logic        ovr_flag,
  output logic        settled
);

  localparam int AW = 16 + DC_SHIFT;

  typedef enum logic {ST_SETTLE, ST_RUN} state_t;

  state_t          state_q, state_d;
  logic [15:0]     x1_q, x1_d;
  logic            ovr1_q, ovr1_d;
  logic            v1_q, v1_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [16:0]     y2_q, y2_d;
  logic            v2_q, v2_d;
  logic [15:0]     dout_q, dout_d;
  logic            dvalid_q, dvalid_d;
  logic [7:0]      ovr_cnt_q, ovr_cnt_d;
  logic            ovr_flag_q, ovr_flag_d;
  logic [15:0]     settle_cnt_q, settle_cnt_d;

  logic [15:0]     dc;
  logic            upd;

  // acc is exactly 16+DC_SHIFT bits, so acc >>> DC_SHIFT truncated to 16 is its top slice
  assign dc  = acc_q[DC_SHIFT +: 16];
  assign upd = en && v1_q;

  always_comb begin
    state_d      = state_q;
    x1_d         = x1_q;
    ovr1_d       = ovr1_q;
    v1_d         = v1_q;
    acc_d        = acc_q;
    y2_d         = y2_q;
    v2_d         = v2_q;
    dout_d       = dout_q;
    dvalid_d     = 1'b0;
    ovr_cnt_d    = ovr_cnt_q;
    ovr_flag_d   = ovr_flag_q;
    settle_cnt_d = settle_cnt_q;

    if (en) begin
      x1_d     = {~adc_data_in[11], adc_data_in[10:0], 4'b0000};
      ovr1_d   = (adc_data_in == 12'h000) || (adc_data_in == 12'hFFF);
      v1_d     = 1'b1;
      y2_d     = {x1_q[15], x1_q} - {dc[15], dc};
      v2_d     = v1_q && (state_q == ST_RUN);
      if (y2_q[16] != y2_q[15]) begin
        dout_d = y2_q[16] ? 16'h8000 : 16'h7FFF;
      end else begin
        dout_d = y2_q[15:0];
      end
      dvalid_d = v2_q;
    end

    if (ovr_clr) begin
      ovr_flag_d = 1'b0;
    end

    if (upd) begin
      if (!ovr1_q) begin
        acc_d = acc_q + {{DC_SHIFT{x1_q[15]}}, x1_q} - {{DC_SHIFT{dc[15]}}, dc};
      end
      if (ovr1_q) begin
        ovr_cnt_d = (ovr_cnt_q == 8'hFF) ? 8'hFF : ovr_cnt_q + 8'd1;
        // set after clear so a coincident clear loses
        if (ovr_cnt_q == 8'(OVR_LIMIT - 1)) begin
          ovr_flag_d = 1'b1;
        end
      end else begin
        ovr_cnt_d = 8'd0;
      end
      if (state_q == ST_SETTLE) begin
        settle_cnt_d = settle_cnt_q + 16'd1;
        if (settle_cnt_q == 16'(SETTLE_CYC - 1)) begin
          state_d = ST_RUN;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= ST_SETTLE;
      x1_q         <= '0;
      ovr1_q       <= 1'b0;
      v1_q         <= 1'b0;
      acc_q        <= '0;
      y2_q         <= '0;
      v2_q         <= 1'b0;
      dout_q       <= '0;
      dvalid_q     <= 1'b0;
      ovr_cnt_q    <= '0;
      ovr_flag_q   <= 1'b0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      x1_q         <= x1_d;
      ovr1_q       <= ovr1_d;
      v1_q         <= v1_d;
      acc_q        <= acc_d;
      y2_q         <= y2_d;
      v2_q         <= v2_d;
      dout_q       <= dout_d;
      dvalid_q     <= dvalid_d;
      ovr_cnt_q    <= ovr_cnt_d;
      ovr_flag_q   <= ovr_flag_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dvalid_q && en;
  assign dc_est     = dc;
  assign ovr_flag   = ovr_flag_q;
  assign settled    = (state_q == ST_RUN);

endmodule

// File: tb/tb_adc_frontend.sv
// tb/tb_adc_frontend.sv - directed self-checking bench for adc_frontend
module tb_adc_frontend;

  localparam int S = 1024;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        en;
  logic [11:0] adc;
  logic        ovr_clr;
  logic [15:0] data_out;
  logic        data_valid;
  logic [15:0] dc_est;
  logic        ovr_flag;
  logic        settled;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 sys_clk = ~sys_clk;

  adc_frontend #(.DC_SHIFT(10), .OVR_LIMIT(16), .SETTLE_CYC(S)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .en         (en),
    .adc_data_in(adc),
    .ovr_clr    (ovr_clr),
    .data_out   (data_out),
    .data_valid (data_valid),
    .dc_est     (dc_est),
    .ovr_flag   (ovr_flag),
    .settled    (settled)
  );

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; en = 1'b1; ovr_clr = 1'b0; adc = 12'h800;
    repeat (3) step();
    tests_run++;
    if ({data_out, data_valid, dc_est, ovr_flag, settled} !== 35'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got dout=%h dv=%b dc=%h ovr=%b st=%b want all 0", data_out, data_valid, dc_est, ovr_flag, settled);
    end
    sys_rst = 1'b0;
    for (int n = 1; n <= S + 4; n++) begin
      step();
      if (n == S) begin
        tests_run++;
        if (settled !== 1'b0) begin tests_failed++; $display("FAIL settled_early edge %0d got %b want 0", n, settled); end
      end
      if (n == S + 1) begin
        tests_run++;
        if (settled !== 1'b1) begin tests_failed++; $display("FAIL settled_rise edge %0d got %b want 1", n, settled); end
      end
      if (n == S + 2) begin
        tests_run++;
        if (data_valid !== 1'b0) begin tests_failed++; $display("FAIL valid_early edge %0d got %b want 0", n, data_valid); end
      end
      if (n >= S + 3) begin
        tests_run++;
        if (data_valid !== 1'b1 || data_out !== 16'h0000) begin
          tests_failed++;
          $display("FAIL valid_rise edge %0d got dv=%b dout=%h want dv=1 dout=0000", n, data_valid, data_out);
        end
      end
    end
  endtask

  task automatic test_enable_pause();
    logic [15:0] q[$];
    logic [15:0] held, held_dc, exp_v;
    q = {16'h0000, 16'h0000};
    for (int k = 1; k <= 12; k++) begin
      if (k == 7) begin
        en = 1'b0;
        held = data_out;
        held_dc = dc_est;
        for (int p = 0; p < 100; p++) begin
          adc = 12'h900 + 12'(p);
          step();
          tests_run++;
          if (data_valid !== 1'b0 || data_out !== held || dc_est !== held_dc) begin
            tests_failed++;
            $display("FAIL pause_frozen cyc %0d got dv=%b dout=%h dc=%h want dv=0 dout=%h dc=%h", p, data_valid, data_out, dc_est, held, held_dc);
          end
        end
        en = 1'b1;
      end
      adc = 12'h800 + 12'(k);
      q.push_back(16'(16 * k - (8 * k * (k - 1)) / 1024));
      step();
      exp_v = q.pop_front();
      tests_run++;
      if (data_out !== exp_v || data_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL ramp_out k=%0d got dout=%h dv=%b want dout=%h dv=1", k, data_out, data_valid, exp_v);
      end
    end
  endtask

  task automatic test_convergence();
    logic [15:0] prev;
    bit mono_ok;
    int d;
    adc = 12'hA00;
    prev = dc_est;
    mono_ok = 1'b1;
    repeat (16384) begin
      step();
      if ($signed(dc_est) < $signed(prev)) mono_ok = 1'b0;
      prev = dc_est;
    end
    tests_run++;
    if (mono_ok !== 1'b1) begin tests_failed++; $display("FAIL dc_monotonic got 0 want 1"); end
    d = int'($signed(dc_est)) - 32'sh2000;
    tests_run++;
    if (d > 16 || d < -16) begin tests_failed++; $display("FAIL dc_converge got %h want 2000 +/-10", dc_est); end
    d = int'($signed(data_out));
    tests_run++;
    if (d > 16 || d < -16 || data_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL residual got dout=%h dv=%b want |dout|<=0010 dv=1", data_out, data_valid);
    end
  endtask

  task automatic test_saturation();
    adc = 12'h000;
    step();
    adc = 12'hA00;
    step();
    step();
    tests_run++;
    if (data_out !== 16'h8000 || data_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_neg got dout=%h dv=%b want 8000 dv=1", data_out, data_valid);
    end
    adc = 12'h100;
    repeat (2000) step();
    adc = 12'hFFE;
    step();
    adc = 12'h100;
    step();
    step();
    tests_run++;
    if (data_out !== 16'h7FFF || data_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_pos got dout=%h dv=%b want 7fff dv=1", data_out, data_valid);
    end
  endtask

  task automatic test_overrange();
    logic [15:0] dc0;
    adc = 12'hFFF;
    step();
    dc0 = dc_est;
    for (int i = 1; i <= 14; i++) begin
      step();
      tests_run++;
      if (dc_est !== dc0 || ovr_flag !== 1'b0) begin
        tests_failed++;
        $display("FAIL ovr15_hold i=%0d got dc=%h ovr=%b want dc=%h ovr=0", i, dc_est, ovr_flag, dc0);
      end
    end
    adc = 12'h800;
    step();
    tests_run++;
    if (dc_est !== dc0 || ovr_flag !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovr15_last got dc=%h ovr=%b want dc=%h ovr=0", dc_est, ovr_flag, dc0);
    end
    step();
    tests_run++;
    if (ovr_flag !== 1'b0 || dc_est === dc0) begin
      tests_failed++;
      $display("FAIL ovr15_resume got dc=%h ovr=%b want dc!=%h ovr=0", dc_est, ovr_flag, dc0);
    end
    adc = 12'h000;
    repeat (16) step();
    tests_run++;
    if (ovr_flag !== 1'b0) begin tests_failed++; $display("FAIL ovr16_early got %b want 0", ovr_flag); end
    ovr_clr = 1'b1;
    step();
    tests_run++;
    if (ovr_flag !== 1'b1) begin tests_failed++; $display("FAIL ovr16_set_wins got %b want 1", ovr_flag); end
    ovr_clr = 1'b0;
    adc = 12'h800;
    step();
    tests_run++;
    if (ovr_flag !== 1'b1) begin tests_failed++; $display("FAIL ovr_sticky got %b want 1", ovr_flag); end
    ovr_clr = 1'b1;
    step();
    tests_run++;
    if (ovr_flag !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear got %b want 0", ovr_flag); end
    ovr_clr = 1'b0;
  endtask

  task automatic test_reset_midrun();
    adc = 12'h800;
    repeat (2) step();
    tests_run++;
    if (settled !== 1'b1 || data_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_run got st=%b dv=%b want 1 1", settled, data_valid);
    end
    sys_rst = 1'b1;
    step();
    tests_run++;
    if ({data_out, data_valid, dc_est, ovr_flag, settled} !== 35'd0) begin
      tests_failed++;
      $display("FAIL midrun_reset got dout=%h dv=%b dc=%h ovr=%b st=%b want all 0", data_out, data_valid, dc_est, ovr_flag, settled);
    end
    sys_rst = 1'b0;
    for (int n = 1; n <= S + 3; n++) begin
      step();
      if (n == S) begin
        tests_run++;
        if (settled !== 1'b0) begin tests_failed++; $display("FAIL rerun_settled_early got %b want 0", settled); end
      end
      if (n == S + 1) begin
        tests_run++;
        if (settled !== 1'b1) begin tests_failed++; $display("FAIL rerun_settled got %b want 1", settled); end
      end
      if (n == S + 2) begin
        tests_run++;
        if (data_valid !== 1'b0) begin tests_failed++; $display("FAIL rerun_valid_early got %b want 0", data_valid); end
      end
      if (n == S + 3) begin
        tests_run++;
        if (data_valid !== 1'b1 || data_out !== 16'h0000) begin
          tests_failed++;
          $display("FAIL rerun_valid got dv=%b dout=%h want dv=1 dout=0000", data_valid, data_out);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_enable_pause();
    test_convergence();
    test_saturation();
    test_overrange();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
